kpyd_scanner: RTL

Parametrised matrix-keypad scanner, the successor to the fixed 4x4 debounced keypad. It drives active-low columns one at a time and samples synchronised active-low rows. Each key is debounced by a stable-sample count, and ghosted multi-key reads are rejected. The block emits press, auto-repeat and release events through a small ready/valid event FIFO into the downstream consumer (display/command logic).

---
 rtl/kpyd_pkg.sv | 24 ++
 rtl/kpyd_event_fifo.sv | 47 ++++
 rtl/kpyd_sync.sv | 21 ++
 rtl/kpyd_scanner.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/kpyd_pkg.sv
// Shared types for the matrix-keypad scanner: scan states, the event record
// carried through the event FIFO, and the key-code width helper.
package kpyd_pkg;

  // Widest code needed by an 8x8 matrix; narrower builds use the low bits.
  localparam int unsigned CODE_W_MAX = 6;

  typedef enum logic [1:0] {
    SCAN,
    CONFIRM,
    HELD
  } scan_state_e;

  typedef struct packed {
    logic [CODE_W_MAX-1:0] code;
    logic                  press;
    logic                  rpt;
  } kpyd_event_t;

  function automatic int unsigned code_width(input int unsigned rows, input int unsigned cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

endpackage

// File: rtl/kpyd_event_fifo.sv
// Show-ahead ready/valid event FIFO; pointers carry an extra wrap bit so
// full and empty are distinguished without a separate counter.
module kpyd_event_fifo import kpyd_pkg::*; #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = kpyd_event_t
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  T           mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop on the same edge frees the slot the push lands in.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // NOTE: storage is not reset; empty/full come from the reset pointers, so
  // the array stays plain registers/RAM without reset fan-out.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  assign data_o = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/kpyd_sync.sv
// Two-flop synchroniser for one asynchronous level input.
module kpyd_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  // NOTE: sequential state uses <= so every flop samples the pre-edge value.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) ff_q <= {2{RESET_VAL}};
    else          ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/kpyd_scanner.sv
// Matrix-keypad scanner: one-cold column drive, per-key debounce, ghost
// rejection, optional typematic repeat, and a press/repeat/release event FIFO.
module kpyd_scanner import kpyd_pkg::*; #(
  parameter int unsigned ROWS            = 4,
  parameter int unsigned COLS            = 4,
  parameter int unsigned SETTLE_CYCLES   = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_EN       = 0,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_PERIOD   = 32,
  parameter int unsigned RELEASE_EVT     = 1,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [ROWS-1:0]                     kpyd_row_i,
  output logic [COLS-1:0]                     kpyd_col_o,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic [code_width(ROWS, COLS)-1:0]   code_o,
  output logic                                press_o,
  output logic                                repeat_o,
  output logic                                overflow_o
);

  localparam int unsigned CODE_W   = code_width(ROWS, COLS);
  localparam int unsigned RIDX_W   = $clog2(ROWS);
  localparam int unsigned CIDX_W   = $clog2(COLS);
  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RPT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W    = $clog2(RPT_MAX + 1);

  logic [ROWS-1:0] row_s, row_low;

  for (genvar r = 0; r < ROWS; r++) begin : g_sync
    kpyd_sync #(.RESET_VAL(1'b1)) u_sync (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .d_i     (kpyd_row_i[r]),
      .q_o     (row_s[r])
    );
  end

  assign row_low = ~row_s;

  scan_state_e         state_q, state_d;
  logic [CIDX_W-1:0]   c_q, c_d, c_next;
  logic [RIDX_W-1:0]   r_q, r_d, low_idx;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [DEB_W-1:0]    deb_q, deb_d;
  logic [RPT_W-1:0]    rpt_q, rpt_d, rpt_tgt;
  logic                first_q, first_d;
  logic [COLS-1:0]     col_q;
  logic                overflow_q;

  logic                  scan_active, one_low, match;
  logic [CODE_W_MAX-1:0] cur_code;
  logic                  push, pop, full, empty, drop;
  kpyd_event_t           ev, head;

  // Columns idle (all ones) only until the first edge after reset.
  assign scan_active = ~&col_q;
  assign one_low     = (row_low != '0) && ((row_low & (row_low - ROWS'(1))) == '0);
  assign match       = (row_low == (ROWS'(1) << r_q));
  assign c_next      = (c_q == CIDX_W'(COLS - 1)) ? '0 : c_q + CIDX_W'(1);
  assign cur_code    = CODE_W_MAX'(int'(r_q) * COLS + int'(c_q));
  assign rpt_tgt     = first_q ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_PERIOD - 1);

  always_comb begin
    low_idx = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_low[r]) low_idx = RIDX_W'(r);
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    r_d      = r_q;
    settle_d = settle_q;
    deb_d    = deb_q;
    rpt_d    = rpt_q;
    first_d  = first_q;
    push     = 1'b0;
    ev       = '{code: cur_code, press: 1'b1, rpt: 1'b0};

    unique case (state_q)
      SCAN: begin
        if (scan_active) begin
          if (settle_q == SETTLE_W'(SETTLE_CYCLES)) begin
            if (one_low) begin
              r_d     = low_idx;
              deb_d   = '0;
              state_d = CONFIRM;
            end else begin
              c_d      = c_next;
              settle_d = '0;
            end
          end else begin
            settle_d = settle_q + SETTLE_W'(1);
          end
        end
      end

      CONFIRM: begin
        if (!match) begin
          state_d  = SCAN;
          c_d      = c_next;
          settle_d = '0;
        end else if (deb_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          push    = 1'b1;
          state_d = HELD;
          deb_d   = '0;
          rpt_d   = '0;
          first_d = 1'b1;
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end

      HELD: begin
        if (REPEAT_EN != 0) begin
          if (rpt_q == rpt_tgt) begin
            push    = 1'b1;
            ev.rpt  = 1'b1;
            rpt_d   = '0;
            first_d = 1'b0;
          end else begin
            rpt_d = rpt_q + RPT_W'(1);
          end
        end
        // Only row r matters here; other rows are ignored (no rollover).
        if (row_low[r_q]) begin
          deb_d = '0;
        end else if (deb_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          push     = (RELEASE_EVT != 0);
          ev.press = 1'b0;
          ev.rpt   = 1'b0;
          state_d  = SCAN;
          c_d      = c_next;
          settle_d = '0;
          deb_d    = '0;
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end

      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= SCAN;
      c_q        <= '0;
      r_q        <= '0;
      settle_q   <= '0;
      deb_q      <= '0;
      rpt_q      <= '0;
      first_q    <= 1'b0;
      col_q      <= '1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      r_q        <= r_d;
      settle_q   <= settle_d;
      deb_q      <= deb_d;
      rpt_q      <= rpt_d;
      first_q    <= first_d;
      col_q      <= ~(COLS'(1) << c_d);
      overflow_q <= overflow_q | drop;
    end
  end

  assign pop  = ready_i && !empty;
  assign drop = push && full && !pop;

  kpyd_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (kpyd_event_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push),
    .data_i  (ev),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Upper code bits are spare when the matrix needs fewer than CODE_W_MAX.
  logic head_unused;
  assign head_unused = ^head.code;

  assign kpyd_col_o = col_q;
  assign valid_o    = !empty;
  assign code_o     = valid_o ? head.code[CODE_W-1:0] : '0;
  assign press_o    = valid_o & head.press;
  assign repeat_o   = valid_o & head.rpt;
  assign overflow_o = overflow_q;

endmodule
